// File: rtl/alu_register_stage_if.sv
// Request/result bundle between the ALU datapath and the registered stage.
// The master drives Start/A/Function. The slave returns ALUout/Busy/Valid.
interface alu_register_stage_if;
  logic       Start;
  logic [3:0] A;
  logic [2:0] Function;
  logic [7:0] ALUout;
  logic       Busy;
  logic       Valid;

  modport master (output Start, A, Function, input ALUout, Busy, Valid);
  modport slave  (input Start, A, Function, output ALUout, Busy, Valid);
endinterface

// File: rtl/alu_register_stage.sv
// Accumulator-style result register: single-cycle ops update on the accept edge; 4x4 multiply takes 4 more edges.
// Busy is the only back-pressure: Start is ignored (not queued) while a multiply is running.
module alu_register_stage #(
  parameter int MUL_CYCLES = 4
) (
  input logic                  Clock,
  input logic                  Reset,
  alu_register_stage_if.slave  bus
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [1:0] LAST_STEP = 2'(MUL_CYCLES - 1);

  state_t     state;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [7:0] acc;
  logic [1:0] count;

  logic [3:0] b_cur;
  logic [4:0] sum;
  logic [7:0] op_res;
  logic [7:0] mul_next;

  always_comb begin
    b_cur  = bus.ALUout[3:0];
    sum    = {1'b0, bus.A} + {1'b0, b_cur};
    op_res = bus.ALUout;
    case (bus.Function)
      3'b000,
      3'b001:  op_res = {3'b000, sum};
      3'b010:  op_res = {{4{b_cur[3]}}, b_cur};
      3'b011:  op_res = {7'd0, |(bus.A | b_cur)};
      3'b100:  op_res = {7'd0, |(bus.A & b_cur)};
      3'b101:  op_res = {bus.A, b_cur};
      default: op_res = bus.ALUout;
    endcase
    // One shift-add step; the multiplier bit is selected by the step index.
    mul_next = acc + (b_q[count] ? ({4'b0000, a_q} << count) : 8'h00);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      a_q        <= 4'h0;
      b_q        <= 4'h0;
      acc        <= 8'h00;
      count      <= 2'd0;
      bus.ALUout <= 8'h00;
      bus.Busy   <= 1'b0;
      bus.Valid  <= 1'b0;
    end else begin
      bus.Valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            if (bus.Function == 3'b110) begin
              a_q      <= bus.A;
              b_q      <= b_cur;
              acc      <= 8'h00;
              count    <= 2'd0;
              bus.Busy <= 1'b1;
              state    <= MUL;
            end else begin
              bus.ALUout <= op_res;
              bus.Valid  <= 1'b1;
            end
          end
        end
        MUL: begin
          // ALUout is only written on the final step so partial products stay hidden.
          acc   <= mul_next;
          count <= count + 2'd1;
          if (count == LAST_STEP) begin
            bus.ALUout <= mul_next;
            bus.Valid  <= 1'b1;
            bus.Busy   <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_register_stage.sv
// Bench for alu_register_stage: directed plan steps followed by random traffic against an arithmetic model.
module tb_alu_register_stage;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  alu_register_stage_if bus ();

  alu_register_stage #(.MUL_CYCLES(4)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: result value, pending product and remaining busy edges.
  int m_out       = 0;
  int m_pend      = 0;
  int m_busy_left = 0;
  int m_valid     = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic int ref_op(input int a, input int b, input int f, input int cur);
    case (f)
      0, 1:    return a + b;
      2:       return (b >= 8) ? b + 240 : b;
      3:       return ((a | b) != 0) ? 1 : 0;
      4:       return ((a & b) != 0) ? 1 : 0;
      5:       return a * 16 + b;
      default: return cur;
    endcase
  endfunction

  task automatic model_edge(input int s, input int a, input int f, input int r);
    int b;
    b = m_out % 16;
    m_valid = 0;
    if (r != 0) begin
      m_out       = 0;
      m_busy_left = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        m_out   = m_pend;
        m_valid = 1;
      end
    end else if (s != 0) begin
      if (f == 6) begin
        m_pend      = a * b;
        m_busy_left = 4;
      end else begin
        m_out   = ref_op(a, b, f, m_out);
        m_valid = 1;
      end
    end
  endtask

  task automatic cycle(input logic s, input logic [3:0] a, input logic [2:0] f, input logic r);
    bus.Start    = s;
    bus.A        = a;
    bus.Function = f;
    Reset        = r;
    @(posedge Clock);
    model_edge(int'(s), int'(a), int'(f), int'(r));
    #1;
    chk("model_alu_out", bus.ALUout, 8'(m_out));
    chk("model_busy",    {7'd0, bus.Busy},  (m_busy_left > 0) ? 8'd1 : 8'd0);
    chk("model_valid",   {7'd0, bus.Valid}, 8'(m_valid));
  endtask

  initial begin
    bus.Start    = 1'b1;
    bus.A        = 4'h5;
    bus.Function = 3'b000;

    // Reset held with Start high.
    cycle(1'b1, 4'h5, 3'b000, 1'b1);
    chk("rst_alu_out", bus.ALUout, 8'h00);
    chk("rst_busy",    {7'd0, bus.Busy},  8'h00);
    chk("rst_valid",   {7'd0, bus.Valid}, 8'h00);
    cycle(1'b1, 4'h5, 3'b000, 1'b1);

    // Add chain.
    cycle(1'b1, 4'h5, 3'b000, 1'b0);
    chk("add_5", bus.ALUout, 8'h05);
    chk("add_5_valid", {7'd0, bus.Valid}, 8'h01);
    cycle(1'b1, 4'hF, 3'b001, 1'b0);
    chk("add_f", bus.ALUout, 8'h14);
    chk("b2b_valid", {7'd0, bus.Valid}, 8'h01);
    cycle(1'b1, 4'h1, 3'b000, 1'b0);
    chk("add_1", bus.ALUout, 8'h05);
    cycle(1'b0, 4'h0, 3'b000, 1'b0);
    chk("idle_valid", {7'd0, bus.Valid}, 8'h00);

    // Sign extend and concatenate.
    cycle(1'b0, 4'h0, 3'b000, 1'b1);
    cycle(1'b1, 4'hA, 3'b000, 1'b0);
    chk("load_0a", bus.ALUout, 8'h0A);
    cycle(1'b1, 4'h0, 3'b010, 1'b0);
    chk("sext", bus.ALUout, 8'hFA);
    cycle(1'b1, 4'h3, 3'b101, 1'b0);
    chk("concat", bus.ALUout, 8'h3A);

    // Multiply 11 * 13 with a stray Start during Busy.
    cycle(1'b0, 4'h0, 3'b000, 1'b1);
    cycle(1'b1, 4'hD, 3'b000, 1'b0);
    chk("load_0d", bus.ALUout, 8'h0D);
    cycle(1'b1, 4'hB, 3'b110, 1'b0);
    chk("mul_busy0", {7'd0, bus.Busy}, 8'h01);
    chk("mul_hold0", bus.ALUout, 8'h0D);
    for (int i = 1; i < 4; i++) begin
      cycle((i == 2) ? 1'b1 : 1'b0, 4'h2, 3'b000, 1'b0);
      chk("mul_busy", {7'd0, bus.Busy}, 8'h01);
      chk("mul_hold", bus.ALUout, 8'h0D);
      chk("mul_novalid", {7'd0, bus.Valid}, 8'h00);
    end
    cycle(1'b0, 4'h0, 3'b000, 1'b0);
    chk("mul_result", bus.ALUout, 8'h8F);
    chk("mul_valid", {7'd0, bus.Valid}, 8'h01);
    chk("mul_done", {7'd0, bus.Busy}, 8'h00);
    cycle(1'b0, 4'h0, 3'b000, 1'b0);
    chk("mul_pulse_end", {7'd0, bus.Valid}, 8'h00);

    // Reset during the second busy cycle aborts the multiply silently.
    cycle(1'b1, 4'h3, 3'b110, 1'b0);
    cycle(1'b0, 4'h0, 3'b000, 1'b0);
    cycle(1'b0, 4'h0, 3'b000, 1'b1);
    chk("abort_alu_out", bus.ALUout, 8'h00);
    chk("abort_busy", {7'd0, bus.Busy}, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'h0, 3'b000, 1'b0);
      chk("abort_novalid", {7'd0, bus.Valid}, 8'h00);
    end

    // Logic ops and hold.
    cycle(1'b1, 4'h0, 3'b011, 1'b0);
    chk("or_zero", bus.ALUout, 8'h00);
    cycle(1'b1, 4'h3, 3'b011, 1'b0);
    chk("or_nonzero", bus.ALUout, 8'h01);
    cycle(1'b1, 4'h2, 3'b100, 1'b0);
    chk("and_zero", bus.ALUout, 8'h00);
    cycle(1'b1, 4'h9, 3'b111, 1'b0);
    chk("hold", bus.ALUout, 8'h00);
    chk("hold_valid", {7'd0, bus.Valid}, 8'h01);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)),
            3'($urandom_range(0, 7)),
            ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
